// File: rtl/alu_pkg.sv
// Shared ALU constants.
package alu_pkg;
    localparam int ALU_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the stage must borrow.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/nbit_sub.sv
// Registered N-bit ripple-borrow subtractor: {Ovflow, D} <= A - B - Bin, one cycle latency.
module nbit_sub
    import alu_pkg::*;
#(
    parameter int Width = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             Bin,
    output logic [Width-1:0] D,
    output logic             Ovflow
);
    logic [Width:0]   brw;
    logic [Width-1:0] d_next;

    assign brw[0] = Bin;

    // The final borrow is the unsigned underflow flag, so B+Bin never needs a wider adder.
    for (genvar i = 0; i < Width; i++) begin : g_stage
        full_sub u_fs (
            .a    (A[i]),
            .b    (B[i]),
            .bin  (brw[i]),
            .d    (d_next[i]),
            .bout (brw[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D      <= '0;
            Ovflow <= 1'b0;
        end else begin
            D      <= d_next;
            Ovflow <= brw[Width];
        end
    end
endmodule

// File: tb/tb_nbit_sub.sv
// Directed and exhaustive checks of nbit_sub at Width 4, 1 and 16.
module tb_nbit_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]  a4 = '0, b4 = '0, d4;
    logic        bin4 = 1'b0, ov4;
    logic [0:0]  a1 = '0, b1 = '0, d1;
    logic        bin1 = 1'b0, ov1;
    logic [15:0] a16 = '0, b16 = '0, d16;
    logic        bin16 = 1'b0, ov16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nbit_sub #(.Width(4)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Bin(bin4), .D(d4), .Ovflow(ov4));
    nbit_sub #(.Width(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin1), .D(d1), .Ovflow(ov1));
    nbit_sub #(.Width(16)) u_w16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Bin(bin16), .D(d16), .Ovflow(ov16));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       ov;
    } vec4_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin;
    endtask

    initial begin
        vec4_t vt[8];
        vt[0] = '{4'd9,  4'd3,  1'b1, 4'd5,  1'b0};
        vt[1] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1};
        vt[2] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};
        vt[3] = '{4'd7,  4'd7,  1'b0, 4'd0,  1'b0};
        vt[4] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b1};
        vt[5] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};
        vt[6] = '{4'd10, 4'd5,  1'b0, 4'd5,  1'b0};
        vt[7] = '{4'd3,  4'd10, 1'b0, 4'd9,  1'b1};

        // Reset state, with clocks running.
        #1;
        chk("rst_d4", d4, 0);
        chk("rst_ov4", ov4, 0);
        tick();
        chk("rst_d16", d16, 0);
        chk("rst_ov16", ov16, 0);

        // First edge after release captures the inputs present at that edge.
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("pre_edge_d", d4, 0);
        tick();
        chk("first_d", d4, 5);
        chk("first_ov", ov4, 0);

        // Change inputs, output must not move before the edge.
        drive4(4'd0, 4'd1, 1'b0);
        #1;
        chk("hold_d", d4, 5);
        chk("hold_ov", ov4, 0);
        tick();
        chk("next_d", d4, 15);
        chk("next_ov", ov4, 1);

        // Asynchronous reset between edges while D=5.
        drive4(4'd9, 4'd3, 1'b1);
        tick();
        chk("pre_rst_d", d4, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_d", d4, 0);
        chk("async_rst_ov", ov4, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_d", d4, 0);
            chk("rst_hold_ov", ov4, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            drive4(vt[i].a, vt[i].b, vt[i].bin);
            tick();
            chk($sformatf("vec%0d_d", i), d4, vt[i].d);
            chk($sformatf("vec%0d_ov", i), ov4, vt[i].ov);
        end

        // Exhaustive Width=4 sweep, one vector per clock.
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    int exp_d;
                    drive4(4'(a), 4'(b), 1'(c));
                    tick();
                    exp_d = (a - b - c) & 15;
                    chk($sformatf("sw4_d a=%0d b=%0d c=%0d", a, b, c), d4, exp_d);
                    chk($sformatf("sw4_ov a=%0d b=%0d c=%0d", a, b, c), ov4, (a < b + c) ? 1 : 0);
                end

        // Exhaustive Width=1.
        for (int v = 0; v < 8; v++) begin
            int a, b, c;
            a = v & 1; b = (v >> 1) & 1; c = (v >> 2) & 1;
            @(negedge clk);
            a1 = 1'(a); b1 = 1'(b); bin1 = 1'(c);
            tick();
            chk($sformatf("w1_d v=%0d", v), d1, (a - b - c) & 1);
            chk($sformatf("w1_ov v=%0d", v), ov1, (a < b + c) ? 1 : 0);
        end

        // Width=16 corners.
        @(negedge clk);
        a16 = 16'h8000; b16 = 16'h0001; bin16 = 1'b1;
        tick();
        chk("w16_a_d", d16, 16'h7FFE);
        chk("w16_a_ov", ov16, 0);
        @(negedge clk);
        a16 = 16'h0000; b16 = 16'hFFFF; bin16 = 1'b0;
        tick();
        chk("w16_b_d", d16, 16'h0001);
        chk("w16_b_ov", ov16, 1);
        @(negedge clk);
        bin16 = 1'b1;
        tick();
        chk("w16_max_d", d16, 16'h0000);
        chk("w16_max_ov", ov16, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
